// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor. A single full-adder cell is
// reused once per clock, LSB first, so a WIDTH-bit result takes WIDTH cycles.
// Subtraction is A + ~B + 1. Sum/Cout/Ovf are registered and change only on
// the completion edge, or on reset.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;     // operand A, shifted right one bit per cycle
  logic [WIDTH-1:0] r_sb;     // operand B or ~B, shifted right one bit per cycle
  logic             r_c;      // running carry between bit positions
  logic [CW-1:0]    r_cnt;    // index of the bit being computed
  logic [WIDTH-1:0] r_pr;     // partial result, filled from the MSB end
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_s;
  logic w_carry;
  logic w_last;
  logic w_accept;

  // One full-adder cell working on the current LSBs.
  assign w_s     = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_carry = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  assign w_last  = (r_cnt == LAST_BIT);

  // A new request is taken in IDLE and in DONE, so operations can run
  // back to back. It is never taken in RUN.
  assign w_accept = Start && (r_state != ST_RUN);

  // Control FSM: IDLE -> RUN for WIDTH cycles -> DONE for one cycle.
  // NOTE: every clocked register uses non-blocking assignments so all of
  // them update from the same pre-edge values, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: r_state <= Start ? ST_RUN : ST_IDLE;
        ST_RUN:           r_state <= w_last ? ST_DONE : ST_RUN;
        default:          r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: load the operands on accept, then shift one bit per RUN cycle.
  // NOTE: these are plain registers, not a memory array, so they are all
  // reset. A reset mid-operation then leaves no stale partial state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      r_pr  <= '0;
    end else if (w_accept) begin
      r_sa  <= A;
      r_sb  <= Sub ? ~B : B;
      r_c   <= Sub ? 1'b1 : Cin;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_c   <= w_carry;
      r_pr  <= {w_s, r_pr[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: written only on the edge that computes the MSB.
  // The carry into the MSB is r_c, and w_carry is the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_sum  <= {w_s, r_pr[WIDTH-1:1]};
      r_cout <= w_carry;
      r_ovf  <= r_c ^ w_carry;
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;
  assign Busy = (r_state == ST_RUN);
  assign Done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random operations on serial_adder (WIDTH=8).
// Expected results come from integer arithmetic on the operands.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Busy;
  logic             Done;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum modulo 2^WIDTH, Cout as the 2^WIDTH bit (no-borrow when
  // subtracting), overflow when the signed result leaves the signed range.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      co = (r >= (1 << WIDTH));
    end else begin
      r  = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end
    s  = r[WIDTH-1:0];
    ov = (sr > ((1 << (WIDTH - 1)) - 1)) || (sr < -(1 << (WIDTH - 1)));
  endtask

  // Presents a request for one edge, then scrambles the inputs, because
  // they only need to be valid at the Start edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom);
    Cin = 1'($urandom); Sub = 1'($urandom);
  endtask

  // Follows an issued operation until Done, or until the cycle budget runs out.
  // Returns at the negedge inside the Done cycle. If inj >= 0, a spurious
  // Start with new operands is pulsed after RUN edge inj.
  task automatic finish_op(input logic [WIDTH-1:0] es, input logic eco, input logic eov,
                           input int inj);
    int n;
    logic stable;
    logic [WIDTH-1:0] s0;
    logic c0, o0;
    @(negedge clk);
    check("busy_after_start", Busy, 1);
    check("done_low_at_start", Done, 0);
    s0 = Sum; c0 = Cout; o0 = Ovf;
    stable = 1'b1;
    n = 0;
    while (!Done && n < 40) begin
      if (n == inj) begin
        A = WIDTH'($urandom); B = WIDTH'($urandom);
        Cin = 1'($urandom); Sub = 1'($urandom); Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (!Done && (Sum !== s0 || Cout !== c0 || Ovf !== o0 || Busy !== 1'b1)) stable = 1'b0;
    end
    check("latency", n, WIDTH);
    check("stable_while_busy", stable, 1);
    check("busy_low_in_done", Busy, 0);
    check("sum", Sum, es);
    check("cout", Cout, eco);
    check("ovf", Ovf, eov);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int inj);
    logic [WIDTH-1:0] es;
    logic eco, eov;
    model(a, b, cin, sub, es, eco, eov);
    issue(a, b, cin, sub);
    finish_op(es, eco, eov, inj);
    @(negedge clk);
    check("done_one_cycle", Done, 0);
    check("idle_after_done", Busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b, es;
    logic cin, sub, eco, eov, quiet;
    int first, second;

    rst = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #1;
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_sum", Sum, 0);
    check("post_rst_busy", Busy, 0);

    // Directed cases from the datasheet.
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, -1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, -1);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, -1);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, -1);

    // A Start pulse at RUN cycle 3 must be ignored.
    run_op(8'h5A, 8'h33, 1'b1, 1'b0, 3);

    // Back to back: a new Start during the Done cycle.
    model(8'h3C, 8'h0F, 1'b0, 1'b0, es, eco, eov);
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    finish_op(es, eco, eov, -1);
    model(8'h10, 8'h20, 1'b0, 1'b1, es, eco, eov);
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    finish_op(es, eco, eov, -1);
    @(negedge clk);
    check("b2b_done_drop", Done, 0);

    // Leave a nonzero result behind, then abort the next operation at RUN
    // cycle 4 with an asynchronous mid-cycle reset.
    run_op(8'h80, 8'h01, 1'b0, 1'b1, -1);
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    check("abort_ovf", Ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== '0) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1);
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, -1);

    // With Start held high, Done comes around every WIDTH+1 cycles.
    A = 8'h9C; B = 8'h71; Cin = 1'b1; Sub = 1'b0; Start = 1'b1;
    model(8'h9C, 8'h71, 1'b1, 1'b0, es, eco, eov);
    first = -1;
    second = -1;
    for (int c = 0; c < 60 && second < 0; c++) begin
      @(negedge clk);
      if (Done) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    Start = 1'b0;
    check("held_period", second - first, WIDTH + 1);
    check("held_sum", Sum, es);
    check("held_cout", Cout, eco);
    @(negedge clk);
    check("held_release_idle", Busy, 0);

    // Random operations, some with spurious Starts and some chained.
    for (int k = 0; k < 24; k++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      model(a, b, cin, sub, es, eco, eov);
      issue(a, b, cin, sub);
      finish_op(es, eco, eov, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH - 1)) : -1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rand_done_drop", Done, 0);
      end
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: one full-adder cell reused over WIDTH clock cycles, LSB first, to add or subtract two WIDTH-bit operands. It extends the single-bit full adder with operand width, subtract mode, signed overflow detection and a start/busy/done handshake. It sits beside the combinational adder as the area-minimal arithmetic option for multi-bit datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled on rising edge of clk
- Sub  input  1  mode, sampled with Start: 0 = A+B+Cin, 1 = A-B (Cin ignored)
- A  input  WIDTH  operand A, sampled with Start
- B  input  WIDTH  operand B, sampled with Start
- Cin  input  1  carry-in, sampled with Start (add mode only)
- Sum  output  WIDTH  result, registered; holds last completed result
- Cout  output  1  carry out of MSB; in subtract mode 1 = no borrow
- Ovf  output  1  two's-complement signed overflow of last result
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse when Sum/Cout/Ovf update

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with Start=1 at an edge: latch A into shift register SA; latch B (Sub=0) or ~B (Sub=1) into SB; carry register C <= Cin (Sub=0) or 1 (Sub=1); bit counter <= 0; go to RUN.
- DONE with Start=0: go to IDLE. IDLE with Start=0: stay.
- RUN, each edge: s = SA[0]^SB[0]^C; C <= majority(SA[0],SB[0],C); SA, SB shift right by 1; s shifted into MSB of partial-result register PR; counter increments.
- On the edge where counter = WIDTH-1 (final bit): Sum <= completed PR; Cout <= final carry; Ovf <= carry into MSB XOR carry out of MSB; go to DONE.
- Start while in RUN is ignored; the operation in flight is not disturbed and inputs are not resampled.
- Sum, Cout, Ovf change only on the completion edge (or reset); they are stable at all other times.
- Arithmetic is modulo 2^WIDTH; Cout is the 2^WIDTH bit; for Sub=1 Cout=1 iff A >= B unsigned.
- Busy = (state == RUN). Done = (state == DONE).

## Timing
- Reset (asynchronous, immediate): state IDLE; Sum=0, Cout=0, Ovf=0, Busy=0, Done=0; internal registers cleared.
- Reset mid-RUN aborts the operation: no Done pulse, outputs cleared to 0.
- Start accepted at edge 0 -> Busy high from edge 0 to edge WIDTH; final bit computed and results registered at edge WIDTH; Done high for exactly the cycle between edges WIDTH and WIDTH+1; Busy low in that cycle.
- Latency Start-edge to valid result: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles, since Start in the DONE cycle is accepted (back-to-back, no idle cycle).
- Start held high continuously: a new operation starts every WIDTH+1 cycles.
- Inputs A, B, Cin, Sub need only be valid at the Start edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; release -> outputs stay 0 until a completed operation.
- Add, WIDTH=8: A=8'h3C, B=8'h0F, Cin=0, Sub=0 -> Busy high 8 cycles, Done one cycle after edge 8, Sum=8'h4B, Cout=0, Ovf=0.
- Carry/overflow: A=8'hFF, B=8'h01, Cin=1 -> Sum=8'h01, Cout=1, Ovf=0; then A=8'h7F, B=8'h01, Cin=0 -> Sum=8'h80, Cout=0, Ovf=1.
- Subtract: A=8'h05, B=8'h07, Sub=1, Cin=1 -> Sum=8'hFE, Cout=0, Ovf=0; A=8'h80, B=8'h01, Sub=1 -> Sum=8'h7F, Cout=1, Ovf=1.
- Handshake: pulse Start with new operands at RUN cycle 3 -> ignored, result matches first operands; Start asserted during Done cycle -> new operation begins, Busy rises next cycle, results update WIDTH cycles later.
- Abort: assert rst at RUN cycle 4 of A=8'h3C+B=8'h0F -> Busy=0, no Done, Sum=0; next Start completes normally with correct result.
